// File: rtl/alu.sv
// Registered 16-function ALU: unsigned operands, 4-bit opcode, result plus carry/flag bit.
// Latency 1 cycle (inputs at edge N visible after edge N); no backpressure, accepts an operation every cycle.
module alu #(
  parameter int WORD_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WORD_WIDTH-1:0]   operand1,
  input  logic [WORD_WIDTH-1:0]   operand2,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  output logic [WORD_WIDTH-1:0]   result,
  output logic                    carryOut
);

  localparam int W = WORD_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHL  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHR  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_ROL  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_ROR  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOR  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_NAND = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_XNOR = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_GT   = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_EQ   = OPCODE_WIDTH'(15);

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] prod;
  logic [W-1:0]   div_den;
  logic [W-1:0]   quot;
  logic           div_zero;
  logic [W-1:0]   result_nxt;
  logic           carry_nxt;

  assign sum      = {1'b0, operand1} + {1'b0, operand2};
  assign diff     = {1'b0, operand1} - {1'b0, operand2};
  assign prod     = {{W{1'b0}}, operand1} * {{W{1'b0}}, operand2};
  assign div_zero = (operand2 == '0);
  // Substitute a unit divisor on zero so the divider never sees B==0; the result is overridden below.
  assign div_den  = div_zero ? W'(1) : operand2;
  assign quot     = operand1 / div_den;

  always_comb begin
    result_nxt = '0;
    carry_nxt  = 1'b0;
    case (opCode)
      OP_ADD: {carry_nxt, result_nxt} = sum;
      OP_SUB: begin
        result_nxt = diff[W-1:0];
        carry_nxt  = diff[W];
      end
      OP_MUL: begin
        result_nxt = prod[W-1:0];
        carry_nxt  = |prod[2*W-1:W];
      end
      OP_DIV: begin
        result_nxt = div_zero ? '1 : quot;
        carry_nxt  = div_zero;
      end
      OP_SHL: begin
        result_nxt = {operand1[W-2:0], 1'b0};
        carry_nxt  = operand1[W-1];
      end
      OP_SHR: begin
        result_nxt = {1'b0, operand1[W-1:1]};
        carry_nxt  = operand1[0];
      end
      OP_ROL: begin
        result_nxt = {operand1[W-2:0], operand1[W-1]};
        carry_nxt  = operand1[W-1];
      end
      OP_ROR: begin
        result_nxt = {operand1[0], operand1[W-1:1]};
        carry_nxt  = operand1[0];
      end
      OP_AND:  result_nxt = operand1 & operand2;
      OP_OR:   result_nxt = operand1 | operand2;
      OP_XOR:  result_nxt = operand1 ^ operand2;
      OP_NOR:  result_nxt = ~(operand1 | operand2);
      OP_NAND: result_nxt = ~(operand1 & operand2);
      OP_XNOR: result_nxt = ~(operand1 ^ operand2);
      OP_GT:   result_nxt[0] = (operand1 > operand2);
      OP_EQ:   result_nxt[0] = (operand1 == operand2);
      default: begin
        result_nxt = '0;
        carry_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      carryOut <= 1'b0;
    end else begin
      result   <= result_nxt;
      carryOut <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: reset sequence, directed vector table, corner-operand sweep and random traffic vs. an arithmetic model.
module tb_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [3:0] opCode;
  logic [7:0] result;
  logic       carryOut;

  int tests = 0;
  int fails = 0;

  alu #(.WORD_WIDTH(8), .OPCODE_WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .operand1 (operand1),
    .operand2 (operand2),
    .opCode   (opCode),
    .result   (result),
    .carryOut (carryOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r;
    logic       exp_c;
  } vec_t;

  // Reference: the opcode map expressed with plain integer arithmetic on 0..255 values.
  function automatic void model(input int op, input int a, input int b, output int r, output int c);
    int p;
    r = 0;
    c = 0;
    case (op)
      0: begin p = a + b; r = p % 256; c = (p > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: begin p = a * b; r = p % 256; c = (p > 255) ? 1 : 0; end
      3: begin
        if (b == 0) begin r = 255; c = 1; end
        else r = a / b;
      end
      4: begin r = (a * 2) % 256; c = a / 128; end
      5: begin r = a / 2; c = a % 2; end
      6: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
      7: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = 255 - (a | b);
      12: r = 255 - (a & b);
      13: r = 255 - (a ^ b);
      14: r = (a > b) ? 1 : 0;
      15: r = (a == b) ? 1 : 0;
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input int exp_r, input int exp_c);
    tests++;
    if (result !== 8'(exp_r) || carryOut !== 1'(exp_c)) begin
      fails++;
      $display("FAIL %s: got result=%02h carry=%0b, expected result=%02h carry=%0b",
               name, result, carryOut, 8'(exp_r), 1'(exp_c));
    end
  endtask

  // Inputs change on the falling edge; the registered output is checked on the following falling edge.
  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    opCode   = op;
    operand1 = a;
    operand2 = b;
    @(negedge clk);
  endtask

  vec_t vecs[$];
  logic [7:0] corner [5];

  initial begin
    int r, c;
    reset    = 1'b1;
    operand1 = 8'hFF;
    operand2 = 8'hFF;
    opCode   = 4'd0;

    // Reset held for two cycles with an overflowing ADD on the inputs.
    @(negedge clk);
    check("reset_cycle1", 0, 0);
    @(negedge clk);
    check("reset_cycle2", 0, 0);
    reset = 1'b0;
    @(negedge clk);
    check("release_add_ff_ff", 8'hFE, 1);

    // Reset asserted mid-stream discards the operation presented with it.
    apply(4'd2, 8'h10, 8'h10);
    check("pre_reset_mul", 8'h00, 1);
    reset = 1'b1;
    apply(4'd3, 8'h12, 8'h00);
    check("midstream_reset", 0, 0);
    reset = 1'b0;
    apply(4'd3, 8'h12, 8'h00);
    check("post_reset_div0", 8'hFF, 1);

    vecs.push_back('{"add_7f_01",  4'd0,  8'h7F, 8'h01, 8'h80, 1'b0});
    vecs.push_back('{"sub_00_01",  4'd1,  8'h00, 8'h01, 8'hFF, 1'b1});
    vecs.push_back('{"sub_05_05",  4'd1,  8'h05, 8'h05, 8'h00, 1'b0});
    vecs.push_back('{"mul_10_10",  4'd2,  8'h10, 8'h10, 8'h00, 1'b1});
    vecs.push_back('{"mul_0f_11",  4'd2,  8'h0F, 8'h11, 8'hFF, 1'b0});
    vecs.push_back('{"div_c8_07",  4'd3,  8'hC8, 8'h07, 8'h1C, 1'b0});
    vecs.push_back('{"div_12_00",  4'd3,  8'h12, 8'h00, 8'hFF, 1'b1});
    vecs.push_back('{"shl_81",     4'd4,  8'h81, 8'h5A, 8'h02, 1'b1});
    vecs.push_back('{"shr_81",     4'd5,  8'h81, 8'hA5, 8'h40, 1'b1});
    vecs.push_back('{"rol_81",     4'd6,  8'h81, 8'hFF, 8'h03, 1'b1});
    vecs.push_back('{"ror_81",     4'd7,  8'h81, 8'h00, 8'hC0, 1'b1});
    vecs.push_back('{"and_f0_3c",  4'd8,  8'hF0, 8'h3C, 8'h30, 1'b0});
    vecs.push_back('{"or_f0_3c",   4'd9,  8'hF0, 8'h3C, 8'hFC, 1'b0});
    vecs.push_back('{"xor_f0_3c",  4'd10, 8'hF0, 8'h3C, 8'hCC, 1'b0});
    vecs.push_back('{"nor_f0_3c",  4'd11, 8'hF0, 8'h3C, 8'h03, 1'b0});
    vecs.push_back('{"nand_f0_3c", 4'd12, 8'hF0, 8'h3C, 8'hCF, 1'b0});
    vecs.push_back('{"xnor_f0_3c", 4'd13, 8'hF0, 8'h3C, 8'h33, 1'b0});
    vecs.push_back('{"gt_f0_3c",   4'd14, 8'hF0, 8'h3C, 8'h01, 1'b0});
    vecs.push_back('{"eq_f0_3c",   4'd15, 8'hF0, 8'h3C, 8'h00, 1'b0});
    vecs.push_back('{"eq_3c_3c",   4'd15, 8'h3C, 8'h3C, 8'h01, 1'b0});
    vecs.push_back('{"gt_3c_f0",   4'd14, 8'h3C, 8'hF0, 8'h00, 1'b0});
    vecs.push_back('{"add_ff_01",  4'd0,  8'hFF, 8'h01, 8'h00, 1'b1});

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].exp_r, vecs[i].exp_c);
    end

    // Every opcode against boundary operands.
    corner[0] = 8'h00;
    corner[1] = 8'h01;
    corner[2] = 8'h7F;
    corner[3] = 8'h80;
    corner[4] = 8'hFF;
    for (int op = 0; op < 16; op++) begin
      for (int ia = 0; ia < 5; ia++) begin
        for (int ib = 0; ib < 5; ib++) begin
          apply(4'(op), corner[ia], corner[ib]);
          model(op, int'(corner[ia]), int'(corner[ib]), r, c);
          check($sformatf("corner_op%0d_%02h_%02h", op, corner[ia], corner[ib]), r, c);
        end
      end
    end

    // Back-to-back random traffic, one operation per cycle.
    for (int n = 0; n < 20000; n++) begin
      int op, a, b;
      op = int'($urandom_range(15, 0));
      a  = int'($urandom_range(255, 0));
      b  = (n % 16 == 0) ? 0 : int'($urandom_range(255, 0));
      apply(4'(op), 8'(a), 8'(b));
      model(op, a, b, r, c);
      check($sformatf("rand_op%0d_%02h_%02h", op, a, b), r, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
